// File: rtl/hilo_mdu_ctrl_pkg.sv
// Shared encodings and constants for the HI/LO multiply/divide sequencer.
package hilo_mdu_ctrl_pkg;

  typedef enum logic [1:0] {
    MDU_MULT  = 2'd0,
    MDU_MULTU = 2'd1,
    MDU_DIV   = 2'd2,
    MDU_DIVU  = 2'd3
  } mdu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mdu_state_e;

  localparam logic [31:0] DIV0_QUOT = 32'hFFFF_FFFF;

  function automatic logic is_div(input mdu_op_e o);
    return (o == MDU_DIV) || (o == MDU_DIVU);
  endfunction

endpackage

// File: rtl/hilo_div_iter.sv
// Radix-2 restoring divider on unsigned magnitudes, one iteration per step.
// The *_nxt_o outputs show the result of the iteration taken on this cycle's step.
module hilo_div_iter (
  input  logic        clk,
  input  logic        load_i,
  input  logic        step_i,
  input  logic [31:0] dividend_i,
  input  logic [31:0] divisor_i,
  output logic [31:0] quo_nxt_o,
  output logic [31:0] rem_nxt_o
);

  logic [31:0] rem_q, quo_q, dvs_q;
  logic [32:0] shifted;
  logic [33:0] diff;
  logic        borrow;

  always_comb begin
    shifted   = {rem_q, quo_q[31]};
    diff      = {1'b0, shifted} - {2'b00, dvs_q};
    borrow    = diff[33];
    quo_nxt_o = {quo_q[30:0], ~borrow};
    // Partial remainder stays below the divisor, so 32 bits always suffice.
    rem_nxt_o = borrow ? shifted[31:0] : diff[31:0];
  end

  always_ff @(posedge clk) begin
    if (load_i) begin
      rem_q <= '0;
      quo_q <= dividend_i;
      dvs_q <= divisor_i;
    end else if (step_i) begin
      rem_q <= rem_nxt_o;
      quo_q <= quo_nxt_o;
    end
  end

endmodule

// File: rtl/hilo_mdu_ctrl.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer issuing one HI/LO write per operation.
// Define HILO_MDU_EARLY_DIV0_EN to complete divide-by-zero in one cycle.
module hilo_mdu_ctrl
  import hilo_mdu_ctrl_pkg::*;
#(
  parameter int unsigned MUL_LAT  = 2,
  parameter int unsigned DIV_ITER = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        flush,
  output logic        stall,
  output logic        done,
  output logic        hilo_we,
  output logic [31:0] hi_wdata,
  output logic [31:0] lo_wdata
);

  mdu_state_e  state_q;
  mdu_op_e     op_q, op_in;
  logic [5:0]  cnt_q;
  logic [31:0] a_q, b_q, hi_q, lo_q;
  logic        done_q;

  logic        accept, div_signed_in;
  logic [31:0] dvd_mag, dvs_mag, quo_nxt, rem_nxt;
  logic [63:0] a_ext, b_ext, prod;
  logic [31:0] res_hi_d, res_lo_d;

  assign op_in         = mdu_op_e'(op);
  assign accept        = start & ~flush & (state_q == IDLE);
  assign div_signed_in = (op_in == MDU_DIV);
  assign dvd_mag       = (div_signed_in && src_a[31]) ? -src_a : src_a;
  assign dvs_mag       = (div_signed_in && src_b[31]) ? -src_b : src_b;

  hilo_div_iter u_div (
    .clk        (clk),
    .load_i     (accept),
    .step_i     (state_q == BUSY),
    .dividend_i (dvd_mag),
    .divisor_i  (dvs_mag),
    .quo_nxt_o  (quo_nxt),
    .rem_nxt_o  (rem_nxt)
  );

  always_comb begin
    a_ext = (op_q == MDU_MULT) ? {{32{a_q[31]}}, a_q} : {32'b0, a_q};
    b_ext = (op_q == MDU_MULT) ? {{32{b_q[31]}}, b_q} : {32'b0, b_q};
    prod  = a_ext * b_ext;
    if (!is_div(op_q)) begin
      res_hi_d = prod[63:32];
      res_lo_d = prod[31:0];
    end else if (b_q == '0) begin
      res_hi_d = a_q;
      res_lo_d = DIV0_QUOT;
    end else begin
      res_lo_d = ((op_q == MDU_DIV) && (a_q[31] ^ b_q[31])) ? -quo_nxt : quo_nxt;
      res_hi_d = ((op_q == MDU_DIV) && a_q[31]) ? -rem_nxt : rem_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      op_q    <= MDU_MULT;
      a_q     <= '0;
      b_q     <= '0;
    end else if (flush) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            op_q <= op_in;
            a_q  <= src_a;
            b_q  <= src_b;
`ifdef HILO_MDU_EARLY_DIV0_EN
            if (is_div(op_in) && (src_b == '0)) begin
              state_q <= DONE;
              done_q  <= 1'b1;
              hi_q    <= src_a;
              lo_q    <= DIV0_QUOT;
            end else begin
              state_q <= BUSY;
              cnt_q   <= is_div(op_in) ? 6'(DIV_ITER) : 6'(MUL_LAT);
            end
`else
            state_q <= BUSY;
            cnt_q   <= is_div(op_in) ? 6'(DIV_ITER) : 6'(MUL_LAT);
`endif
          end
        end
        BUSY: begin
          cnt_q <= cnt_q - 6'd1;
          if (cnt_q == 6'd1) begin
            state_q <= DONE;
            done_q  <= 1'b1;
            hi_q    <= res_hi_d;
            lo_q    <= res_lo_d;
          end
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  // A flush arriving during DONE must still cancel the write already registered.
  assign done     = done_q & ~flush;
  assign hilo_we  = done;
  assign stall    = accept | (state_q == BUSY);
  assign hi_wdata = hi_q;
  assign lo_wdata = lo_q;

endmodule

// File: tb/tb_hilo_mdu_ctrl.sv
// Scoreboard bench for hilo_mdu_ctrl: directed plan cases plus random operations.
// Honours HILO_MDU_EARLY_DIV0_EN for divide-by-zero latency.
module tb_hilo_mdu_ctrl;
  localparam int unsigned MUL_LAT  = 2;
  localparam int unsigned DIV_ITER = 32;

  logic        clk, rst, start, flush;
  logic [1:0]  op;
  logic [31:0] src_a, src_b;
  logic        stall, done, hilo_we;
  logic [31:0] hi_wdata, lo_wdata;

  hilo_mdu_ctrl #(.MUL_LAT(MUL_LAT), .DIV_ITER(DIV_ITER)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .op       (op),
    .src_a    (src_a),
    .src_b    (src_b),
    .flush    (flush),
    .stall    (stall),
    .done     (done),
    .hilo_we  (hilo_we),
    .hi_wdata (hi_wdata),
    .lo_wdata (lo_wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          at;
  } exp_t;
  exp_t sb[$];

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Reference: plain arithmetic on the architectural rules.
  function automatic logic [63:0] ref_model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sbv;
    int     q, r;
    case (o)
      2'd0: begin
        sa  = longint'($signed(a));
        sbv = longint'($signed(b));
        return 64'(sa * sbv);
      end
      2'd1: return {32'b0, a} * {32'b0, b};
      default: begin
        if (b == 32'h0) return {a, 32'hFFFF_FFFF};
        if (o == 2'd3) return {a % b, a / b};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
        q = $signed(a) / $signed(b);
        r = $signed(a) % $signed(b);
        return {32'(r), 32'(q)};
      end
    endcase
  endfunction

  function automatic int latency(input logic [1:0] o, input logic [31:0] b);
    if (!o[1]) return int'(MUL_LAT) + 1;
`ifdef HILO_MDU_EARLY_DIV0_EN
    if (b == 32'h0) return 1;
`endif
    return int'(DIV_ITER) + 1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    exp_t        e;
    logic [63:0] r;
    int          lat;
    lat  = latency(o, b);
    r    = ref_model(o, a, b);
    e.hi = r[63:32];
    e.lo = r[31:0];
    e.at = cyc + lat;
    sb.push_back(e);
    op = o; src_a = a; src_b = b; start = 1'b1;
    #1 check("stall_start", 64'(stall), 64'd1);
    tick();
    start = 1'b0;
    for (int k = 1; k < lat; k++) begin
      check("stall_busy", 64'(stall), 64'd1);
      tick();
    end
    check("stall_done", 64'(stall), 64'd0);
    tick();
    check("hold_after_done", {hi_wdata, lo_wdata}, {e.hi, e.lo});
  endtask

  // Monitor: every write strobe must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (done === 1'b1 || hilo_we === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 64'(done), 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("done_cycle", 64'(cyc), 64'(e.at));
        check("hilo_we_eq_done", 64'(hilo_we), 64'(done));
        check("result", {hi_wdata, lo_wdata}, {e.hi, e.lo});
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  ro;
    logic [31:0] ra, rb;
    rst = 1'b1; start = 1'b0; flush = 1'b0; op = 2'd0; src_a = '0; src_b = '0;
    tick(); tick();
    check("reset_outputs", {29'b0, done, hilo_we, stall, hi_wdata}, 64'd0);
    check("reset_lo", 64'(lo_wdata), 64'd0);
    rst = 1'b0;
    tick();

    run_op(2'd0, 32'hFFFF_FFFF, 32'd2);
    run_op(2'd1, 32'hFFFF_FFFF, 32'd2);
    run_op(2'd3, 32'd100, 32'd7);
    run_op(2'd2, 32'hFFFF_FFF9, 32'd2);
    run_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op(2'd3, 32'h0000_1234, 32'd0);
    run_op(2'd2, 32'hFFFF_FF00, 32'd0);

    // Flush in cycle 10 of a divide, then a multiply from cycle 11.
    op = 2'd2; src_a = 32'd1000; src_b = 32'd3; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (9) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("stall_after_flush", 64'(stall), 64'd0);
    run_op(2'd1, 32'h0001_0000, 32'h0003_0000);

    // Reset in cycle 5 of a divide.
    op = 2'd3; src_a = 32'hDEAD_BEEF; src_b = 32'd5; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_mid_ctrl", {61'b0, done, hilo_we, stall}, 64'd0);
    check("rst_mid_data", {hi_wdata, lo_wdata}, 64'd0);
    repeat (40) tick();

    // Second start during BUSY must be ignored.
    begin
      exp_t e;
      e.hi = 32'd2; e.lo = 32'd14; e.at = cyc + 33;
      sb.push_back(e);
    end
    op = 2'd3; src_a = 32'd100; src_b = 32'd7; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    op = 2'd0; src_a = 32'd5; src_b = 32'd6; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (35) tick();

    // start together with flush is not accepted.
    op = 2'd1; src_a = 32'd9; src_b = 32'd9; start = 1'b1; flush = 1'b1;
    #1 check("stall_start_flush", 64'(stall), 64'd0);
    tick();
    start = 1'b0; flush = 1'b0;
    check("stall_after_start_flush", 64'(stall), 64'd0);
    repeat (40) tick();

    // Flush during DONE suppresses the write.
    op = 2'd0; src_a = 32'd3; src_b = 32'd4; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (int'(MUL_LAT)) tick();
    flush = 1'b1;
    #1 check("flush_in_done", {62'b0, done, hilo_we}, 64'd0);
    tick();
    flush = 1'b0;
    tick();

    for (int i = 0; i < 30; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      case ($urandom_range(0, 5))
        0: rb = 32'h0;
        1: rb = 32'($urandom_range(1, 16));
        2: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        default: rb = $urandom;
      endcase
      run_op(ro, ra, rb);
    end

    repeat (5) tick();
    check("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hilo_mdu_ctrl.md
Name: hilo_mdu_ctrl

Overview:
- Multi-cycle multiply/divide sequencer that produces HI/LO results for MULT, MULTU, DIV and DIVU.
- Sits in the EX stage beside the ALU. It accepts one operation, stalls the pipeline while the operation runs, then issues a single write of both HI and LO into the HI/LO register file.
- MTHI/MTLO/MFHI/MFLO bypass this block and go to the HI/LO register directly.

Parameters:
- MUL_LAT, 2, cycles spent in BUSY for multiply (1..15); models a pipelined multiplier.
- DIV_ITER, 32, radix-2 iterations for divide; fixed at 32, exposed only for bench shortening.

Ports:
- clk  input  1  system clock; all state changes on posedge
- rst  input  1  synchronous active-high reset
- start  input  1  request to begin an operation; sampled only in IDLE
- op  input  2  operation select: 0=MULT, 1=MULTU, 2=DIV, 3=DIVU
- src_a  input  32  rs operand (multiplicand / dividend)
- src_b  input  32  rt operand (multiplier / divisor)
- flush  input  1  exception/branch cancel; aborts any operation in flight
- stall  output  1  pipeline hold request
- done  output  1  one-cycle pulse marking result valid
- hilo_we  output  1  write strobe for HI and LO together; equals done
- hi_wdata  output  32  HI result (high product / remainder)
- lo_wdata  output  32  LO result (low product / quotient)

Behaviour:
- Clocking and reset: clk only; rst is synchronous and active-high. Reset forces state=IDLE, done=0, hilo_we=0, hi_wdata=0, lo_wdata=0 and counter=0. Reset mid-operation discards the operation with no write.
- States:
  - IDLE: on start=1 and flush=0, latch op/src_a/src_b and go to BUSY. For MUL, the counter is loaded with MUL_LAT; for DIV, with DIV_ITER.
  - BUSY: decrement the counter each cycle. DIV performs one restoring iteration per cycle on operand magnitudes. At counter==1, go to DONE.
  - DONE: done=hilo_we=1 for exactly one cycle, then return to IDLE.
- Latency: the start cycle is cycle 0. done is high in cycle MUL_LAT+1 for MUL (3 by default) and in cycle 33 for DIV.
- stall = (start & ~flush & state==IDLE) | (state==BUSY). stall is low in DONE, so the instruction advances while the write lands.
- Arithmetic:
  - MULT is a 64-bit signed product; MULTU is unsigned. {hi,lo}=product.
  - DIV: the quotient sign is the XOR of the operand signs; the remainder takes the dividend's sign (C truncation). Sign fix is applied in the final iteration.
  - Signed overflow, 0x80000000 / 0xFFFFFFFF, gives lo=0x80000000, hi=0.
- Divide by zero (src_b=0), signed or unsigned: hi=src_a, lo=0xFFFFFFFF, written normally.
- A start while not in IDLE is ignored; the operand latches hold.
- flush in any state: next state IDLE, no done or hilo_we. flush in DONE suppresses the write.
- If start and flush are high in the same IDLE cycle, flush wins and nothing is accepted.
- hi_wdata/lo_wdata are registered and hold their last value outside DONE.

Optional Feature:
- Macro: HILO_MDU_EARLY_DIV0_EN.
- When defined: a divide with src_b=0 detected at start skips BUSY and goes straight to DONE; done is in cycle 1 with the same result values.
- When undefined: divide-by-zero runs the full 33-cycle sequence with the forced result above.
- Multiply is unaffected either way.

Decomposition:
- Shared defines package holds:
  - op encodings: MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU
  - state encodings: IDLE, BUSY, DONE
  - DIV0_QUOT constant 0xFFFFFFFF
- One sub-module, hilo_div_iter: a magnitude restoring divider datapath with a one-iteration-per-cycle step enable and a load input. The FSM, sign handling and the multiplier stay in hilo_mdu_ctrl.

Test Plan:
- MULT a=0xFFFFFFFF b=2 -> cycle 3: hi=0xFFFFFFFF, lo=0xFFFFFFFE, stall high in cycles 0-2.
- MULTU a=0xFFFFFFFF b=2 -> hi=0x00000001, lo=0xFFFFFFFE. DIVU a=100 b=7 -> cycle 33: lo=0x0000000E, hi=0x00000002.
- DIV a=0xFFFFFFF9 (-7) b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV a=0x80000000 b=0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU a=0x1234 b=0 -> hi=0x00001234, lo=0xFFFFFFFF. done in cycle 33 without the macro, cycle 1 with it.
- DIV started, flush in cycle 10 -> no done or hilo_we, stall low from cycle 11. A new MULTU started in cycle 11 completes in cycle 14.
- rst in cycle 5 of a DIV -> outputs zero, state IDLE. A second start during BUSY is ignored and only the first result is written. start with flush in the same cycle -> no stall, no operation.
